// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller for HEX0..HEX7: renders a CPU-written 32-bit word as
// eight hex digits, or as a signed decimal via a 24-cycle double-dabble engine.
module hex_display_ctrl #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset_CPU,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_mode,
  output logic        busy,
  output logic        done,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_data;
  logic        r_mode, r_neg, r_ovf;
  logic [23:0] r_mag;
  logic [27:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [6:0]  r_hex [8];
  logic        r_done;

  logic [31:0] w_mag;
  logic        w_ovf, w_accept, w_seen;
  logic [27:0] w_bcd_adj, w_bcd_next;
  logic [6:0]  w_hex [8];

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 0x80000000 negates to itself, so the unsigned compare flags it as overflow.
  assign w_mag    = wr_data[31] ? (32'd0 - wr_data) : wr_data;
  assign w_ovf    = w_mag > 32'd9_999_999;
  assign w_accept = wr_en && (r_state == IDLE);

  always_ff @(posedge clk or negedge reset_CPU) begin
    if (!reset_CPU) r_state <= IDLE;
    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
    else            r_state <= w_next;
  end

  always_comb begin
    // NOTE: every comb output gets a default first; a path that leaves one unassigned would infer a latch.
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (wr_mode && !w_ovf) ? CONV : LOAD;
      CONV:    if (r_cnt == 5'd23) w_next = LOAD;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 7; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    w_bcd_next = {w_bcd_adj[26:0], r_mag[23]};
  end

  always_comb begin
    w_seen = 1'b0;
    for (int n = 0; n < 8; n++) w_hex[n] = SEG_BLANK;
    if (!r_mode) begin
      for (int n = 0; n < 8; n++) w_hex[n] = glyph(r_data[4*n +: 4]);
    end else if (r_ovf) begin
      w_hex[2] = SEG_E;
      w_hex[1] = SEG_R;
      w_hex[0] = SEG_R;
    end else begin
      // Walk from the top digit down; once a nonzero digit is seen, all lower digits show.
      for (int i = 6; i >= 0; i--) begin
        if (r_bcd[4*i +: 4] != 4'd0 || i == 0 || !BLANK_LEADING) w_seen = 1'b1;
        if (w_seen) w_hex[i] = glyph(r_bcd[4*i +: 4]);
      end
      w_hex[7] = r_neg ? SEG_MINUS : SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset_CPU) begin
    if (!reset_CPU) begin
      r_data <= '0;
      r_mode <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_mag  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      // NOTE: the display array is a handful of flops, not a RAM, so it resets to blank like any register.
      for (int n = 0; n < 8; n++) r_hex[n] <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_data <= wr_data;
          r_mode <= wr_mode;
          r_neg  <= wr_data[31];
          r_ovf  <= w_ovf;
          r_mag  <= w_mag[23:0];
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
        CONV: begin
          r_bcd <= w_bcd_next;
          r_mag <= {r_mag[22:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        LOAD: begin
          r_hex  <= w_hex;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
  assign HEX6 = r_hex[6];
  assign HEX7 = r_hex[7];

endmodule
